// File: rtl/seq_det_pkg.sv
// Shared constants and elaboration-time helpers for the serial pattern detector.
package seq_det_pkg;

  localparam int MAX_N     = 32;
  localparam int DEF_CNT_W = 16;

  // Longest proper border of the first k received pattern bits (MSB of pattern is bit 0 received).
  function automatic int border_len(input logic [MAX_N-1:0] pattern, input int n, input int k);
    int   best;
    logic ok;
    best = 0;
    for (int b = 1; b < MAX_N; b++) begin
      if (b < k) begin
        ok = 1'b1;
        for (int i = 0; i < MAX_N; i++) begin
          if (i < b) begin
            if (pattern[n-1-i] != pattern[n-1-(k-b+i)]) ok = 1'b0;
          end
        end
        if (ok) best = b;
      end
    end
    return best;
  endfunction

  // Matched length after consuming bit b with k bits already matched; returns n on a full match.
  function automatic int next_state(input logic [MAX_N-1:0] pattern, input int n, input int k,
                                    input logic b);
    int   j;
    int   res;
    logic done;
    j    = k;
    res  = 0;
    done = 1'b0;
    for (int it = 0; it <= MAX_N; it++) begin
      if (!done) begin
        if (j < n && pattern[n-1-j] == b) begin
          res  = j + 1;
          done = 1'b1;
        end else if (j == 0) begin
          res  = 0;
          done = 1'b1;
        end else begin
          j = border_len(pattern, n, j);
        end
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/seq_detector_param_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count
);

  localparam logic [W-1:0] CNT_MAX = '1;

  logic [W-1:0] count_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else if (clr) begin
      count_q <= '0;
    end else if (inc && count_q != CNT_MAX) begin
      count_q <= count_q + 1'b1;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/seq_detector_param.sv
// Parametrised Mealy serial-pattern detector with KMP fallback, run-time overlap
// selection, input qualification and a saturating match counter.
module seq_detector_param
  import seq_det_pkg::*;
#(
  parameter int             N       = 4,
  parameter logic [N-1:0]   PATTERN = 4'b1101,
  parameter int             CNT_W   = DEF_CNT_W,
  localparam int            LW      = $clog2(N + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic             in_bit,
  input  logic             overlap_en,
  input  logic             clear_cnt,
  output logic             detect,
  output logic [CNT_W-1:0] match_count,
  output logic [LW-1:0]    match_len
);

  if (N < 2 || N > MAX_N) begin : g_bad_n
    $error("seq_detector_param: N must be in 2..32");
  end
  if (CNT_W < 1 || CNT_W > 32) begin : g_bad_cnt_w
    $error("seq_detector_param: CNT_W must be in 1..32");
  end

  localparam logic [MAX_N-1:0] PAT_EXT     = MAX_N'(PATTERN);
  localparam logic [LW-1:0]    FULL_BORDER = LW'(border_len(PAT_EXT, N, N));
  localparam logic [LW-1:0]    LAST_K      = LW'(N - 1);
  localparam logic             LAST_BIT    = PATTERN[0];

  // Per-state successor for each input bit, fixed at elaboration.
  logic [LW-1:0] nxt0 [N];
  logic [LW-1:0] nxt1 [N];

  for (genvar g = 0; g < N; g++) begin : g_tbl
    localparam int NX0 = next_state(PAT_EXT, N, g, 1'b0);
    localparam int NX1 = next_state(PAT_EXT, N, g, 1'b1);
    assign nxt0[g] = LW'(NX0);
    assign nxt1[g] = LW'(NX1);
  end

  logic [LW-1:0] k_q;
  logic [LW-1:0] k_d;

  always_comb begin
    detect = in_valid && (k_q == LAST_K) && (in_bit == LAST_BIT);
    k_d    = k_q;
    if (in_valid) begin
      if (detect) begin
        k_d = overlap_en ? FULL_BORDER : '0;
      end else begin
        k_d = in_bit ? nxt1[k_q] : nxt0[k_q];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      k_q <= '0;
    end else begin
      k_q <= k_d;
    end
  end

  assign match_len = k_q;

  sat_counter #(
    .W(CNT_W)
  ) u_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (clear_cnt),
    .inc   (detect),
    .count (match_count)
  );

endmodule

// File: tb/tb_seq_detector_param.sv
// Scoreboard bench: four detector instances share one stimulus stream, each
// checked against a window-based reference model of the pattern rules.
module tb_seq_detector_param;

  logic clk = 1'b0;
  logic reset, in_valid, in_bit, overlap_en, clear_cnt;

  logic        det0, det1, det2, det3;
  logic [2:0]  len0, len1, len2;
  logic [3:0]  len3;
  logic [15:0] cnt0, cnt1, cnt3;
  logic [1:0]  cnt2;

  always #5 clk = ~clk;

  seq_detector_param #(.N(4), .PATTERN(4'b1101), .CNT_W(16)) u0 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_bit(in_bit), .overlap_en(overlap_en),
    .clear_cnt(clear_cnt), .detect(det0), .match_count(cnt0), .match_len(len0));
  seq_detector_param #(.N(4), .PATTERN(4'b1110), .CNT_W(16)) u1 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_bit(in_bit), .overlap_en(overlap_en),
    .clear_cnt(clear_cnt), .detect(det1), .match_count(cnt1), .match_len(len1));
  seq_detector_param #(.N(4), .PATTERN(4'b1101), .CNT_W(2)) u2 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_bit(in_bit), .overlap_en(overlap_en),
    .clear_cnt(clear_cnt), .detect(det2), .match_count(cnt2), .match_len(len2));
  seq_detector_param #(.N(8), .PATTERN(8'hA5), .CNT_W(16)) u3 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_bit(in_bit), .overlap_en(overlap_en),
    .clear_cnt(clear_cnt), .detect(det3), .match_count(cnt3), .match_len(len3));

  typedef struct packed {
    logic [3:0]       det;
    logic [3:0][7:0]  len;
    logic [3:0][31:0] cnt;
  } exp_t;

  exp_t q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  logic [31:0] pat_m  [4] = '{32'hD, 32'hE, 32'hD, 32'hA5};
  int          n_m    [4] = '{4, 4, 4, 8};
  int          cmax_m [4] = '{65535, 65535, 3, 65535};
  bit          win    [4][32];
  int          wlen   [4];
  int          cnt_m  [4];

  task automatic report(input string nm, input int act, input int exp_v);
    n_tests++;
    if (act != exp_v) begin
      n_fail++;
      if (n_fail <= 40) $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, exp_v, $time);
    end
  endtask

  // True when the last L received bits equal the first L pattern bits.
  function automatic bit tail_is_prefix(input int d, input int L);
    bit ok;
    ok = (L <= wlen[d]);
    for (int i = 0; i < 32; i++) begin
      if (ok && i < L) begin
        if (win[d][wlen[d]-L+i] != pat_m[d][n_m[d]-1-i]) ok = 1'b0;
      end
    end
    return ok;
  endfunction

  function automatic int cur_len(input int d);
    int best;
    best = 0;
    for (int L = 1; L < 32; L++) begin
      if (L < n_m[d] && tail_is_prefix(d, L)) best = L;
    end
    return best;
  endfunction

  task automatic drive(input bit v, input bit b, input bit ov, input bit clr, input bit rst,
                       input bit push = 1'b1);
    exp_t e;
    bit   det;
    @(negedge clk);
    in_valid   = v;
    in_bit     = b;
    overlap_en = ov;
    clear_cnt  = clr;
    reset      = rst;
    for (int d = 0; d < 4; d++) begin
      e.len[d] = 8'(cur_len(d));
      e.cnt[d] = 32'(cnt_m[d]);
      det      = 1'b0;
      if (v) begin
        if (wlen[d] == n_m[d]) begin
          for (int i = 0; i < 31; i++) win[d][i] = win[d][i+1];
          wlen[d]--;
        end
        win[d][wlen[d]] = b;
        wlen[d]++;
        det = (wlen[d] == n_m[d]) && tail_is_prefix(d, n_m[d]);
        if (det && !ov) wlen[d] = 0;
      end
      e.det[d] = det;
      if (rst) begin
        wlen[d]  = 0;
        cnt_m[d] = 0;
      end else if (clr) begin
        cnt_m[d] = 0;
      end else if (det && cnt_m[d] < cmax_m[d]) begin
        cnt_m[d]++;
      end
    end
    if (push) q.push_back(e);
  endtask

  task automatic send(input logic [31:0] bits, input int nb, input bit ov);
    for (int i = nb - 1; i >= 0; i--) drive(1'b1, bits[i], ov, 1'b0, 1'b0);
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    #1;
  endtask

  task automatic rst_cycle();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  // Monitor: pops the expectation for the current cycle once inputs have settled.
  initial begin
    exp_t e;
    int   alen [4];
    int   acnt [4];
    logic [3:0] adet;
    forever begin
      @(negedge clk);
      #2;
      if (q.size() != 0) begin
        e       = q.pop_front();
        adet    = {det3, det2, det1, det0};
        alen[0] = int'(len0); alen[1] = int'(len1); alen[2] = int'(len2); alen[3] = int'(len3);
        acnt[0] = int'(cnt0); acnt[1] = int'(cnt1); acnt[2] = int'(cnt2); acnt[3] = int'(cnt3);
        for (int d = 0; d < 4; d++) begin
          report($sformatf("detect[u%0d]", d), int'(adet[d]), int'(e.det[d]));
          report($sformatf("match_len[u%0d]", d), alen[d], int'(e.len[d]));
          report($sformatf("match_count[u%0d]", d), acnt[d], int'(e.cnt[d]));
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    bit          ov, v, b, clr;
    int          inj;
    logic [7:0]  pat8;
    int          waited;
    reset = 1'b1; in_valid = 1'b0; in_bit = 1'b0; overlap_en = 1'b0; clear_cnt = 1'b0;
    for (int d = 0; d < 4; d++) begin
      wlen[d]  = 0;
      cnt_m[d] = 0;
    end

    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    rst_cycle();

    send(32'b1101101, 7, 1'b1);
    idle();
    report("overlap_count", int'(cnt0), 2);

    rst_cycle();
    send(32'b1101101, 7, 1'b0);
    idle();
    report("nonoverlap_count", int'(cnt0), 1);

    rst_cycle();
    send(32'b1111, 4, 1'b1);
    send(32'b0, 1, 1'b1);
    #1;
    report("kmp_len_after_4", int'(len1), 3);
    report("kmp_detect_bit5", int'(det1), 1);
    idle();
    report("kmp_len_after_5", int'(len1), 0);
    report("kmp_count", int'(cnt1), 1);

    rst_cycle();
    send(32'b11, 2, 1'b1);
    drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    #1;
    report("gap_len_hold", int'(len0), 2);
    drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    #1;
    report("gap_detect", int'(det0), 1);

    rst_cycle();
    for (int i = 0; i < 6; i++) send(32'b1101, 4, 1'b0);
    idle();
    report("sat_count", int'(cnt2), 3);
    send(32'b110, 3, 1'b0);
    drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    #1;
    report("clear_with_detect", int'(det2), 1);
    idle();
    report("clear_wins", int'(cnt2), 0);

    rst_cycle();
    send(32'b110, 3, 1'b1);
    rst_cycle();
    drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    #1;
    report("rst_mid_detect", int'(det0), 0);
    idle();
    report("rst_mid_len", int'(len0), 1);
    report("rst_mid_count", int'(cnt0), 0);

    rst_cycle();
    pat8 = 8'hA5;
    inj  = 0;
    for (int i = 0; i < 10000; i++) begin
      ov  = (i < 5000) ^ ($urandom_range(0, 99) == 0);
      v   = ($urandom_range(0, 9) != 0);
      clr = ($urandom_range(0, 299) == 0);
      if (inj == 0 && $urandom_range(0, 15) == 0) inj = 8;
      if (inj > 0 && v) begin
        b = pat8[inj-1];
        inj--;
      end else begin
        b = 1'($urandom_range(0, 1));
      end
      drive(v, b, ov, clr, 1'b0);
    end
    idle();
    report("sweep_final_count", int'(cnt3), cnt_m[3]);

    waited = 0;
    while (q.size() != 0 && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    #5;
    if (q.size() != 0) report("scoreboard_drain", q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/seq_detector_param.md
Name: seq_detector_param

Overview:
Parametrised Mealy serial-pattern detector, the generalised successor to the fixed 4-bit "1101" detector. The pattern, its length and the counter width are parameters. Overlapping or non-overlapping detection is selected at run time. The block adds input qualification, a saturating match counter and a progress output. It sits on a serial bit stream in front of framing/sync logic that consumes `detect` and `match_count`.

Parameters:
N, 4, pattern length in bits; legal range 2..32 (elaboration error outside range)
PATTERN, 4'b1101, N-bit pattern; MSB is the first bit received
CNT_W, 16, width of `match_count`; legal range 1..32

Ports:
clk  input  1  clock; all state updates on its rising edge
reset  input  1  synchronous, active-high reset
in_valid  input  1  qualifies `in_bit`; when low, the cycle is ignored
in_bit  input  1  serial data bit
overlap_en  input  1  1 = overlapping detection, 0 = non-overlapping; read combinationally each valid cycle
clear_cnt  input  1  synchronous clear of `match_count`
detect  output  1  Mealy match pulse; combinational from state, `in_valid` and `in_bit`
match_count  output  CNT_W  saturating count of detections
match_len  output  $clog2(N+1)  bits of the pattern currently matched (registered state), range 0..N-1

Behaviour:
- Clock and reset: one clock `clk`; `reset` is synchronous and active-high.
- Reset values: state = 0, `match_len` = 0, `match_count` = 0. `detect` = 0 while state = 0 unless the current input completes an N = 1 match, which cannot occur because N >= 2.
- State: k = number of matched leading pattern bits, 0..N-1. Transition tables are built at elaboration from PATTERN with a KMP failure function. No runtime search.
- Valid cycle, `in_bit` equals the expected bit PATTERN[N-1-k], k < N-1: next k = k+1; `detect` = 0.
- Valid cycle, mismatch: fall back along the failure chain to the longest border b of the matched prefix for which PATTERN[N-1-b] == `in_bit`; next k = b+1. If no border matches, next k = 0. This rule applies in both modes, so no partial match is lost (e.g. PATTERN 1110 on input 11110 detects).
- Valid cycle completing the pattern (k = N-1 and the bit matches):
  - `detect` = 1 in the same cycle (zero latency, Mealy).
  - If `overlap_en` = 1: next k = length of the longest proper border of the full PATTERN.
  - If `overlap_en` = 0: next k = 0.
- `in_valid` = 0: state holds, `detect` = 0, counter holds. `in_bit` and `overlap_en` are don't-care.
- `match_count`:
  - Increments by 1 on each cycle with `detect` = 1.
  - Saturates at 2^CNT_W - 1 and never wraps.
  - `clear_cnt` = 1 sets the count to 0 next cycle; `clear_cnt` wins over a simultaneous detect.
  - `clear_cnt` does not affect detector state.
- `reset` has priority over everything. Asserting it mid-sequence discards partial matches. `detect` is not gated by `reset` combinationally, but no state or count update occurs on a reset cycle.
- A change of `overlap_en` takes effect on the first valid cycle in which it is sampled. There is no pipeline delay.

Decomposition:
- Shared package `seq_det_pkg`:
  - constant MAX_N = 32
  - default CNT_W
  - constant function `border_len(pattern, n, k)` used to build the fallback and overlap tables at elaboration
- One sub-module: `sat_counter` (parameter W; ports clk, reset, clr, inc, count). It is instantiated for `match_count` and is reusable elsewhere.

Test Plan:
- Overlap vs non-overlap: PATTERN 1101, stream 1,1,0,1,1,0,1 all valid.
  - `overlap_en` = 1 → `detect` on bits 4 and 7, `match_count` = 2.
  - `overlap_en` = 0 → `detect` on bit 4 only, `match_count` = 1.
- KMP fallback: N = 4, PATTERN 1110, stream 1,1,1,1,0 → `detect` on bit 5 only. `match_len` sequence after each bit is 1,2,3,3,0.
- Valid gaps: PATTERN 1101, bits 1,1,(in_valid = 0, in_bit = 0),0,1 → `detect` on the last bit. The invalid cycle leaves `match_len` = 2.
- Saturation and clear: CNT_W = 2, six back-to-back 1101 matches (non-overlap) → `match_count` reads 1,2,3,3,3,3. Then `clear_cnt` together with a detect → `match_count` = 0.
- Reset mid-sequence: PATTERN 1101, bits 1,1,0, then `reset` for 1 cycle, then bit 1 → `detect` = 0, `match_len` = 1, `match_count` = 0.
- Parameter sweep: N = 8, PATTERN 8'hA5, random 10k-bit stream against a reference model, both `overlap_en` values → exact `detect` per cycle and final `match_count`.
